// File: rtl/fifo_pkt_pkg.sv
// Shared types and default widths for the show-ahead FIFO and its packet reader.
package fifo_pkt_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int AWIDTH_DEF = 4;
  localparam int TWIDTH_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_pkt_reader.sv
// Drains a show-ahead FIFO into a registered valid/ready stream framed with sop/eop,
// starting full packets at a fill threshold and flushing short packets on an idle timeout.
module fifo_pkt_reader
  import fifo_pkt_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int TWIDTH = TWIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  input  logic [AWIDTH:0]   fifo_usedw_i,
  output logic              fifo_rdreq_o,
  input  logic [AWIDTH:0]   pkt_len_i,
  input  logic [TWIDTH-1:0] timeout_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  output logic              sop_o,
  output logic              eop_o,
  input  logic              ready_i,
  output logic              busy_o
);

  localparam int LW = AWIDTH + 1;

  state_e            state_q, state_d;
  logic [LW-1:0]     words_left_q, words_left_d;
  logic              first_q, first_d;
  logic [TWIDTH-1:0] idle_cnt_q, idle_cnt_d;
  logic [DWIDTH-1:0] data_q;
  logic              valid_q, sop_q, eop_q;

  logic              slot_free;
  logic              full_hit;
  logic              timeout_hit;
  logic [LW-1:0]     eff_left;
  logic              eff_first;
  logic              rdreq;

  // The IDLE start decision feeds the read strobe in the same cycle, so a
  // following packet is fetched while the previous last word is still draining.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    eff_left    = '0;
    eff_first   = 1'b0;
    slot_free   = !valid_q || ready_i;
    full_hit    = (pkt_len_i != '0) && (fifo_usedw_i >= pkt_len_i);
    timeout_hit = (timeout_i != '0) && !fifo_empty_i &&
                  (idle_cnt_q == timeout_i - TWIDTH'(1));

    if (state_q == SEND) begin
      eff_left  = words_left_q;
      eff_first = first_q;
    end else if (full_hit) begin
      eff_left  = pkt_len_i;
      eff_first = 1'b1;
    end else if (timeout_hit) begin
      eff_left  = fifo_usedw_i;
      eff_first = 1'b1;
    end

    rdreq        = (eff_left != '0) && !fifo_empty_i && slot_free;
    words_left_d = eff_left - LW'(rdreq);
    first_d      = rdreq ? 1'b0 : eff_first;
    state_d      = (words_left_d != '0) ? SEND : IDLE;

    if (state_q == SEND || fifo_empty_i || eff_left != '0) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != '1) begin
      idle_cnt_d = idle_cnt_q + TWIDTH'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      first_q      <= 1'b0;
      idle_cnt_q   <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      words_left_q <= words_left_d;
      first_q      <= first_d;
      idle_cnt_q   <= idle_cnt_d;
      if (rdreq) begin
        data_q  <= fifo_q_i;
        valid_q <= 1'b1;
        sop_q   <= eff_first;
        eop_q   <= (eff_left == LW'(1));
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
        sop_q   <= 1'b0;
        eop_q   <= 1'b0;
      end
    end
  end

  assign fifo_rdreq_o = rdreq;
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign sop_o        = sop_q;
  assign eop_o        = eop_q;
  assign busy_o       = (state_q == SEND);

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader: a small show-ahead FIFO model feeds the DUT
// and a beat monitor logs every accepted word for comparison against hand-computed packets.
module tb_fifo_pkt_reader;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic [15:0] fifo_q_i = '0;
  logic        fifo_empty_i = 1'b1;
  logic [4:0]  fifo_usedw_i = '0;
  logic        fifo_rdreq_o;
  logic [4:0]  pkt_len_i = '0;
  logic [7:0]  timeout_i = '0;
  logic [15:0] data_o;
  logic        valid_o, sop_o, eop_o, busy_o;
  logic        ready_i = 1'b1;

  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] fifo_mem[$];
  logic [15:0] b_data[$];
  logic        b_sop[$];
  logic        b_eop[$];
  int          b_cyc[$];
  int          cyc = 0;
  int          rd_cnt = 0;
  int          stall_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] hold_data = '0;
  logic        hold_sop = 1'b0, hold_eop = 1'b0;

  fifo_pkt_reader dut (
    .clk_i        (clk_i),
    .arstn_i      (arstn_i),
    .fifo_q_i     (fifo_q_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_usedw_i (fifo_usedw_i),
    .fifo_rdreq_o (fifo_rdreq_o),
    .pkt_len_i    (pkt_len_i),
    .timeout_i    (timeout_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .sop_o        (sop_o),
    .eop_o        (eop_o),
    .ready_i      (ready_i),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Show-ahead FIFO model with no status lag; emptied on reset.
  always @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      fifo_mem.delete();
    end else begin
      if (fifo_rdreq_o && fifo_mem.size() > 0) void'(fifo_mem.pop_front());
      if (wr_en) fifo_mem.push_back(wr_data);
    end
    fifo_empty_i <= (fifo_mem.size() == 0);
    fifo_usedw_i <= 5'(fifo_mem.size());
    fifo_q_i     <= (fifo_mem.size() > 0) ? fifo_mem[0] : 16'h0000;
  end

  // Monitor on the falling edge: logs accepted beats, checks stall stability.
  always @(negedge clk_i) begin
    cyc++;
    if (arstn_i) begin
      if (fifo_rdreq_o) rd_cnt++;
      if (stall_prev) begin
        check("stall_valid", 32'(valid_o), 1);
        check("stall_data", 32'(data_o), 32'(hold_data));
        check("stall_sop", 32'(sop_o), 32'(hold_sop));
        check("stall_eop", 32'(eop_o), 32'(hold_eop));
      end
      if (valid_o && !ready_i) begin
        check("no_rd_stall", 32'(fifo_rdreq_o), 0);
        stall_cnt++;
        hold_data = data_o;
        hold_sop  = sop_o;
        hold_eop  = eop_o;
      end
      stall_prev = valid_o && !ready_i;
      if (valid_o && ready_i) begin
        b_data.push_back(data_o);
        b_sop.push_back(sop_o);
        b_eop.push_back(eop_o);
        b_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic clear_logs();
    b_data.delete();
    b_sop.delete();
    b_eop.delete();
    b_cyc.delete();
    rd_cnt     = 0;
    stall_cnt  = 0;
    stall_prev = 1'b0;
  endtask

  task automatic do_reset();
    arstn_i = 1'b0;
    tick(2);
    arstn_i = 1'b1;
    clear_logs();
    tick(1);
  endtask

  task automatic write_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 16'(i);
      tick(1);
    end
    wr_en = 1'b0;
  endtask

  // Expected framing: words base+i, packets of len words, last packet may be short.
  task automatic check_beats(input string tag, input int n_exp, input logic [15:0] base,
                             input int len);
    int n;
    check({tag, "_count"}, 32'(b_data.size()), 32'(n_exp));
    n = (b_data.size() < n_exp) ? b_data.size() : n_exp;
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, 32'(b_data[i]), 32'(base + 16'(i)));
      check({tag, "_sop"}, 32'(b_sop[i]), 32'((i % len) == 0));
      check({tag, "_eop"}, 32'(b_eop[i]), 32'(((i % len) == len - 1) || (i == n_exp - 1)));
    end
  endtask

  initial begin
    int pat[4] = '{1, 0, 0, 1};
    int gap;

    // Reset state
    tick(2);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_sop", 32'(sop_o), 0);
    check("rst_eop", 32'(eop_o), 0);
    check("rst_data", 32'(data_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_rdreq", 32'(fifo_rdreq_o), 0);
    arstn_i = 1'b1;
    clear_logs();
    tick(1);

    // One exact 4-word packet
    pkt_len_i = 5'd4;
    timeout_i = 8'd0;
    write_words(16'hA0A0, 4);
    tick(12);
    check_beats("t1", 4, 16'hA0A0, 4);
    check("t1_rdreq_cnt", 32'(rd_cnt), 4);
    if (b_cyc.size() == 4) check("t1_consecutive", 32'(b_cyc[3] - b_cyc[0]), 3);

    // Ten words: two back-to-back packets, remaining two flushed by timeout
    do_reset();
    pkt_len_i = 5'd4;
    timeout_i = 8'd20;
    write_words(16'hB000, 10);
    tick(12);
    check("t2_held_before_timeout", 32'(b_data.size()), 8);
    tick(30);
    check_beats("t2", 10, 16'hB000, 4);
    check("t2_rdreq_cnt", 32'(rd_cnt), 10);
    if (b_cyc.size() == 10) begin
      check("t2_no_bubble", 32'(b_cyc[7] - b_cyc[0]), 7);
      gap = b_cyc[8] - b_cyc[7];
      check("t2_flush_gap", 32'(gap >= 20 && gap <= 22), 1);
    end

    // Short packet flushed by timeout
    do_reset();
    pkt_len_i = 5'd8;
    timeout_i = 8'd5;
    write_words(16'hC000, 1);
    gap = cyc;
    write_words(16'hC001, 2);
    tick(25);
    check_beats("t3", 3, 16'hC000, 8);
    if (b_cyc.size() > 0) begin
      gap = b_cyc[0] - gap;
      check("t3_timeout_delay", 32'(gap >= 5 && gap <= 6), 1);
    end
    check("t3_rdreq_cnt", 32'(rd_cnt), 3);

    // Backpressure: ready pattern 1,0,0,1 while two 2-word packets drain
    do_reset();
    pkt_len_i = 5'd2;
    timeout_i = 8'd0;
    for (int i = 0; i < 24; i++) begin
      ready_i = pat[i % 4][0];
      wr_en   = (i < 4);
      wr_data = 16'hD000 + 16'(i);
      tick(1);
    end
    wr_en   = 1'b0;
    ready_i = 1'b1;
    tick(4);
    check_beats("t4", 4, 16'hD000, 2);
    check("t4_stalls_seen", 32'(stall_cnt > 0), 1);
    check("t4_rdreq_cnt", 32'(rd_cnt), 4);

    // Both triggers disabled: FIFO content is never read
    do_reset();
    pkt_len_i = 5'd0;
    timeout_i = 8'd0;
    write_words(16'hE000, 3);
    tick(30);
    check("t5_no_beats", 32'(b_data.size()), 0);
    check("t5_no_rdreq", 32'(rd_cnt), 0);
    check("t5_not_busy", 32'(busy_o), 0);

    // Reset mid-packet, then a fresh packet
    do_reset();
    pkt_len_i = 5'd4;
    timeout_i = 8'd0;
    write_words(16'hF000, 4);
    for (int i = 0; i < 30 && b_data.size() < 2; i++) @(negedge clk_i);
    check("t6_two_beats", 32'(b_data.size()), 2);
    check("t6_mid_valid", 32'(valid_o), 1);
    #2;
    arstn_i = 1'b0;
    #1;
    check("t6_async_valid", 32'(valid_o), 0);
    check("t6_async_sop", 32'(sop_o), 0);
    check("t6_async_eop", 32'(eop_o), 0);
    check("t6_async_busy", 32'(busy_o), 0);
    tick(2);
    arstn_i = 1'b1;
    clear_logs();
    tick(1);
    write_words(16'h5A00, 4);
    tick(10);
    check_beats("t6_fresh", 4, 16'h5A00, 4);
    check("t6_rdreq_cnt", 32'(rd_cnt), 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_pkt_reader.md
Name: fifo_pkt_reader

Overview:
- Downstream consumer of the show-ahead FIFO (DWIDTH 16, AWIDTH 4).
- Drains the FIFO into a registered valid/ready stream, framed as packets with sop/eop.
- Starts a packet of pkt_len_i words once the FIFO holds at least that many.
- Flushes a short packet of whatever is present if data sits below threshold for timeout_i cycles.

Parameters:
DWIDTH, 16, data word width (matches FIFO).
AWIDTH, 4, FIFO address width; usedw and length fields are AWIDTH+1 bits.
TWIDTH, 8, width of timeout_i and the idle counter.

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous active-low reset
fifo_q_i  in  DWIDTH  FIFO show-ahead head word, valid when fifo_empty_i=0
fifo_empty_i  in  1  FIFO empty
fifo_usedw_i  in  AWIDTH+1  FIFO fill level
fifo_rdreq_o  out  1  FIFO read acknowledge (pops head)
pkt_len_i  in  AWIDTH+1  full packet length; sampled in IDLE only
timeout_i  in  TWIDTH  idle cycles before partial flush; 0 disables flush
data_o  out  DWIDTH  stream data
valid_o  out  1  stream valid
sop_o  out  1  first word of packet, qualified by valid_o
eop_o  out  1  last word of packet, qualified by valid_o
ready_i  in  1  downstream ready
busy_o  out  1  state==SEND

Behaviour:
- Reset (arstn_i low, async): state=IDLE, valid_o=0, sop_o=0, eop_o=0, data_o=0, words_left=0, idle_cnt=0.
- fifo_rdreq_o is combinational; all other outputs are registered.
- Output slot free when !valid_o || ready_i.
- IDLE state:
  - idle_cnt increments, saturating, each cycle !fifo_empty_i.
  - idle_cnt clears when the FIFO is empty or on leaving IDLE.
  - If pkt_len_i!=0 and fifo_usedw_i>=pkt_len_i: go to SEND, words_left=pkt_len_i, first=1. This has priority over timeout.
  - Else if timeout_i!=0, !fifo_empty_i and idle_cnt==timeout_i-1 (the timeout_i-th qualifying cycle): go to SEND, words_left=fifo_usedw_i (>=1), first=1.
  - pkt_len_i > 2**AWIDTH never triggers a full packet; only the timeout can drain.
- SEND state:
  - fifo_rdreq_o = (words_left!=0) && !fifo_empty_i && slot free.
  - On rdreq: data_o<=fifo_q_i, valid_o<=1, sop_o<=first, eop_o<=(words_left==1), first<=0, words_left decrements.
  - When words_left reaches 0, return to IDLE.
  - A new packet may start the next cycle while the last word still waits in the output register. Its first read is gated by slot free.
- No rdreq while valid_o && !ready_i: data_o, sop_o and eop_o hold stable and valid_o stays 1. Downstream must never see data change under stall.
- valid_o && ready_i with no rdreq this cycle: valid_o<=0, sop_o<=0, eop_o<=0.
- Full throughput is 1 word/cycle with ready_i held high; no bubble between back-to-back packets.
- Mid-packet FIFO empty cannot occur (captured words are present and this block is the only reader). If it does, rdreq gating holds the state; there is no error recovery.
- Reset asserted mid-packet: abort immediately and drop the partial packet. FIFO contents are the FIFO's responsibility.
- fifo_empty_i / fifo_usedw_i may lag the FIFO by one register stage. Decisions are taken only in IDLE, and words_left never exceeds the words actually present.

Decomposition:
- Package fifo_pkt_pkg: state enum (IDLE, SEND), and default DWIDTH/AWIDTH/TWIDTH constants shared with the FIFO top.
- Single module; no sub-module is warranted.
- The output register plus slot-free logic is the only candidate. It stays inline.

Test Plan:
- pkt_len_i=4, write 4 words A0..A3, ready_i=1: 4 consecutive beats A0..A3, sop on A0, eop on A3, fifo_rdreq_o high exactly 4 cycles.
- pkt_len_i=4, write 10 words, ready_i=1: two 4-word packets back-to-back with no idle beat. Remaining 2 words held until the timeout flush.
- pkt_len_i=8, timeout_i=5, write 3 words then stop: after 5 non-empty idle cycles, one 3-word packet with sop+eop framing; no further beats.
- pkt_len_i=2, ready_i toggles 1,0,0,1 during a packet: data_o/sop_o/eop_o stable while stalled; no rdreq while slot busy; all words delivered in order.
- timeout_i=0, pkt_len_i=0, write 3 words: no output, fifo_rdreq_o never asserted.
- Assert arstn_i mid-packet (after 2 of 4 beats): valid_o, sop_o and eop_o drop asynchronously, state IDLE. After release, behaviour matches a fresh start.
